axi4_master_write_address: RTL and testbench

- AXI4 master-side write address (AW) channel driver; the initiator counterpart of the slave AW channel block.
- Accepts write commands from a local command interface and buffers them in a small FIFO.
- Rejects illegal commands, then issues them on AW with a valid/ready handshake.
- Limits in-flight transactions, using write-response completion pulses as credits.

---
 rtl/axi4_master_write_address_if.sv | 53 +++++
 rtl/axi4_master_write_address.sv | 148 ++++++++++++++
 tb/tb_axi4_master_write_address.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_master_write_address_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_master_write_address_if
// Description : Command, AW channel and write-completion signals for the
//               AXI4 master write-address driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_master_write_address_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int BURST_LENGTH    = 8,
    parameter int MAX_OUTSTANDING = 4
) ();
    logic                                   cmd_valid;
    logic                                   cmd_ready;
    logic [ADDR_WIDTH-1:0]                  cmd_addr;
    logic [ID_WIDTH-1:0]                    cmd_id;
    logic [BURST_LENGTH-1:0]                cmd_len;
    logic [2:0]                             cmd_size;
    logic [1:0]                             cmd_burst;
    logic                                   cmd_err;

    logic                                   awvalid;
    logic                                   awready;
    logic [ADDR_WIDTH-1:0]                  awaddr;
    logic [ID_WIDTH-1:0]                    awid;
    logic [BURST_LENGTH-1:0]                awlen;
    logic [2:0]                             awsize;
    logic [1:0]                             awburst;

    logic                                   b_done;
    logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding;
    logic                                   idle;

    modport master (
        input  cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
        output cmd_ready, cmd_err,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        input  b_done,
        output outstanding, idle
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready, cmd_err,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        output b_done,
        input  outstanding, idle
    );
endinterface
`default_nettype wire

// File: rtl/axi4_master_write_address.sv
`default_nettype none
// ============================================================================
// Module      : axi4_master_write_address
// Description : AXI4 master AW channel driver with command FIFO, legality
//               filter and outstanding-transaction credit limit.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_master_write_address #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int BURST_LENGTH    = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input wire                          clk,
    input wire                          rst,
    axi4_master_write_address_if.master bus
);
    localparam int         c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int         c_CNT_W   = c_PTR_W + 1;
    localparam int         c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int         c_ENTRY_W = ADDR_WIDTH + ID_WIDTH + BURST_LENGTH + 5;
    localparam logic [2:0] c_MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    localparam logic [0:0] c_AW_IDLE  = 1'b0;
    localparam logic [0:0] c_AW_VALID = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [c_ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_OUT_W-1:0]      r_outstanding;
    logic                    r_cmd_err;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ID_WIDTH-1:0]     r_awid;
    logic [BURST_LENGTH-1:0] r_awlen;
    logic [2:0]              r_awsize;
    logic [1:0]              r_awburst;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_wrap_len_ok;
    logic                    w_illegal;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_credit;
    logic                    w_load_ok;
    logic                    w_bdec;
    logic [c_ENTRY_W-1:0]    w_cmd_entry;

    assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.cmd_valid && !w_full;

    assign w_wrap_len_ok = (bus.cmd_len == BURST_LENGTH'(1)) || (bus.cmd_len == BURST_LENGTH'(3)) ||
                           (bus.cmd_len == BURST_LENGTH'(7)) || (bus.cmd_len == BURST_LENGTH'(15));
    assign w_illegal = (bus.cmd_burst == 2'b11) ||
                       ((bus.cmd_burst == 2'b10) && !w_wrap_len_ok) ||
                       (bus.cmd_size > c_MAX_SIZE);
    assign w_push      = w_accept && !w_illegal;
    assign w_cmd_entry = {bus.cmd_addr, bus.cmd_id, bus.cmd_len, bus.cmd_size, bus.cmd_burst};

    // Credit uses the registered count only; a same-edge b_done frees nothing yet.
    assign w_credit  = (r_outstanding < c_OUT_W'(MAX_OUTSTANDING));
    assign w_load_ok = !w_empty && w_credit;
    assign w_bdec    = bus.b_done && (r_outstanding != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_AW_IDLE: begin
                if (w_load_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_AW_VALID;
                end
            end
            c_AW_VALID: begin
                if (bus.awready) begin
                    if (w_load_ok) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_AW_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_AW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_AW_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_cmd_err     <= 1'b0;
            r_awaddr      <= '0;
            r_awid        <= '0;
            r_awlen       <= '0;
            r_awsize      <= '0;
            r_awburst     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_err <= w_accept && w_illegal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                {r_awaddr, r_awid, r_awlen, r_awsize, r_awburst} <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case ({w_pop, w_bdec})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign bus.cmd_ready   = !w_full;
    assign bus.cmd_err     = r_cmd_err;
    assign bus.awvalid     = (r_state == c_AW_VALID);
    assign bus.awaddr      = r_awaddr;
    assign bus.awid        = r_awid;
    assign bus.awlen       = r_awlen;
    assign bus.awsize      = r_awsize;
    assign bus.awburst     = r_awburst;
    assign bus.outstanding = r_outstanding;
    assign bus.idle        = w_empty && (r_state == c_AW_IDLE) && (r_outstanding == '0);
endmodule
`default_nettype wire

// File: tb/tb_axi4_master_write_address.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_master_write_address
// Description : Scoreboard bench for the AXI4 master AW channel driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_master_write_address;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;

    logic        rand_mode   = 1'b0;
    logic        awready_man = 1'b0;
    logic        bdone_man   = 1'b0;
    logic        rnd_awready = 1'b0;
    logic        rnd_bdone   = 1'b0;
    logic        pre_awvalid = 1'b0;
    logic        stall_prev  = 1'b0;
    logic [48:0] prev_aw     = '0;
    logic [48:0] exp_q [$];

    axi4_master_write_address_if #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .BURST_LENGTH(8), .MAX_OUTSTANDING(4)
    ) bus ();

    axi4_master_write_address #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .BURST_LENGTH(8),
        .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.awready = rand_mode ? rnd_awready : awready_man;
    assign bus.b_done  = rand_mode ? rnd_bdone   : bdone_man;

    always @(posedge clk) begin
        #1;
        rnd_awready = 1'($urandom_range(0, 1));
        rnd_bdone   = ($urandom_range(0, 2) == 0);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // AW monitor: scoreboard compare on handshake, hold check while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check_val("aw_hold_valid", 64'(bus.awvalid), 64'(1));
                check_val("aw_hold_fields", 64'({bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst}),
                          64'(prev_aw));
            end
            if (bus.awvalid && bus.awready) begin
                n_hs++;
                check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    check_val("aw_fields", 64'({bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst}),
                              64'(exp_q.pop_front()));
                end
            end
        end
        stall_prev = bus.awvalid && !bus.awready && !rst;
        prev_aw    = {bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst};
    end

    task automatic send_cmd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input bit legal);
        int waited;
        waited        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_id    = id;
        bus.cmd_len   = len;
        bus.cmd_size  = sz;
        bus.cmd_burst = bu;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) check_val("cmd_accept_timeout", 64'(bus.cmd_ready), 64'(1));
        pre_awvalid = bus.awvalid;
        if (legal) exp_q.push_back({a, id, len, sz, bu});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_random(input int idx);
        logic [1:0] bu;
        logic [2:0] sz;
        logic [7:0] ln;
        bu = 2'($urandom_range(0, 2));
        sz = 3'($urandom_range(0, 2));
        ln = 8'($urandom_range(0, 255));
        if (bu == 2'b10) ln = 8'((1 << $urandom_range(1, 4)) - 1);
        send_cmd(32'h8000_0000 + 32'(idx * 64), 4'(idx), ln, sz, bu, 1'b1);
    endtask

    task automatic pulse_bdone();
        bdone_man = 1'b1;
        @(posedge clk);
        #1;
        bdone_man = 1'b0;
    endtask

    task automatic drain_outstanding();
        for (int k = 0; k < 8 && bus.outstanding != 0; k++) pulse_bdone();
        check_val("drain_outstanding", 64'(bus.outstanding), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int k;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_id    = '0;
        bus.cmd_len   = '0;
        bus.cmd_size  = '0;
        bus.cmd_burst = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_awvalid", 64'(bus.awvalid), 64'(0));
        check_val("rst_aw_fields", 64'({bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst}), 64'(0));
        check_val("rst_cmd_err", 64'(bus.cmd_err), 64'(0));
        check_val("rst_outstanding", 64'(bus.outstanding), 64'(0));
        check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_val("rst_idle", 64'(bus.idle), 64'(1));

        // Single INCR command with awready tied high.
        awready_man = 1'b1;
        send_cmd(32'h1000, 4'd3, 8'd7, 3'd2, 2'b01, 1'b1);
        check_val("t1_no_valid_pre_accept", 64'(pre_awvalid), 64'(0));
        check_val("t1_no_valid_accept_cycle", 64'(bus.awvalid), 64'(0));
        @(posedge clk); #1;
        check_val("t1_valid_latency", 64'(bus.awvalid), 64'(1));
        check_val("t1_outstanding", 64'(bus.outstanding), 64'(1));
        check_val("t1_cmd_err", 64'(bus.cmd_err), 64'(0));
        @(posedge clk); #1;
        check_val("t1_valid_one_cycle", 64'(bus.awvalid), 64'(0));
        check_val("t1_handshakes", 64'(n_hs), 64'(1));
        pulse_bdone();
        check_val("t1_bdone_dec", 64'(bus.outstanding), 64'(0));
        pulse_bdone();
        check_val("bdone_at_zero", 64'(bus.outstanding), 64'(0));

        // Fill with awready low, then release; credit limit stops at four.
        awready_man = 1'b0;
        base = n_hs;
        for (int i = 0; i < 5; i++) send_cmd(32'h2000 + 32'(i * 16), 4'(i + 4), 8'(i), 3'd1, 2'b01, 1'b1);
        check_val("t2_fifo_full", 64'(bus.cmd_ready), 64'(0));
        check_val("t2_valid_waiting", 64'(bus.awvalid), 64'(1));
        awready_man = 1'b1;
        send_cmd(32'h2050, 4'd9, 8'd3, 3'd0, 2'b00, 1'b1);
        for (k = 0; k < 50 && bus.awvalid; k++) @(negedge clk);
        check_val("t3_handshakes_at_limit", 64'(n_hs - base), 64'(4));
        check_val("t3_outstanding_max", 64'(bus.outstanding), 64'(4));
        pulse_bdone();
        check_val("t3_bdone_no_same_edge_load", 64'(bus.awvalid), 64'(0));
        check_val("t3_out_after_bdone", 64'(bus.outstanding), 64'(3));
        pulse_bdone();
        check_val("t3_load_with_bdone_valid", 64'(bus.awvalid), 64'(1));
        check_val("t3_load_with_bdone_out", 64'(bus.outstanding), 64'(3));
        repeat (3) @(posedge clk);
        #1;
        check_val("t3_all_issued", 64'(n_hs - base), 64'(6));
        check_val("t3_out_final", 64'(bus.outstanding), 64'(4));
        check_val("t3_not_idle", 64'(bus.idle), 64'(0));
        drain_outstanding();
        check_val("t3_idle", 64'(bus.idle), 64'(1));

        // Illegal commands: WRAP len 5, burst 11, size 3; then a legal WRAP.
        send_cmd(32'h3000, 4'd1, 8'd5, 3'd2, 2'b10, 1'b0);
        check_val("ill_wrap_err", 64'(bus.cmd_err), 64'(1));
        @(posedge clk); #1;
        check_val("ill_wrap_err_clear", 64'(bus.cmd_err), 64'(0));
        check_val("ill_wrap_no_valid", 64'(bus.awvalid), 64'(0));
        send_cmd(32'h3100, 4'd2, 8'd0, 3'd0, 2'b11, 1'b0);
        check_val("ill_burst_err", 64'(bus.cmd_err), 64'(1));
        @(posedge clk); #1;
        check_val("ill_burst_no_valid", 64'(bus.awvalid), 64'(0));
        send_cmd(32'h3200, 4'd3, 8'd0, 3'd3, 2'b01, 1'b0);
        check_val("ill_size_err", 64'(bus.cmd_err), 64'(1));
        @(posedge clk); #1;
        check_val("ill_size_no_valid", 64'(bus.awvalid), 64'(0));
        check_val("ill_fifo_empty_idle", 64'(bus.idle), 64'(1));
        send_cmd(32'h3300, 4'd4, 8'd3, 3'd2, 2'b10, 1'b1);
        check_val("legal_wrap_no_err", 64'(bus.cmd_err), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        drain_outstanding();

        // Random awready / b_done with 20 commands.
        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) send_random(i);
        for (k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
        check_val("rand_sb_drained", 64'(exp_q.size()), 64'(0));
        awready_man = 1'b1;
        rand_mode   = 1'b0;
        @(posedge clk); #1;
        drain_outstanding();

        // Reset mid-burst with three commands queued.
        awready_man = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(32'h4000 + 32'(i * 4), 4'(i), 8'd1, 3'd2, 2'b01, 1'b1);
        check_val("t6_valid_before_rst", 64'(bus.awvalid), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_val("t6_awvalid", 64'(bus.awvalid), 64'(0));
        check_val("t6_awaddr", 64'(bus.awaddr), 64'(0));
        check_val("t6_outstanding", 64'(bus.outstanding), 64'(0));
        check_val("t6_idle", 64'(bus.idle), 64'(1));
        check_val("t6_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check_val("t6_stays_idle", 64'(bus.awvalid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
